// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I ALU decode stage: ALU operation
// encodings, decoded opcodes and the entry carried through the output buffer.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD     = 4'b0000,
      ALU_SUB     = 4'b0001,
      ALU_SLL     = 4'b0010,
      ALU_SLTU    = 4'b0011,
      ALU_XOR     = 4'b0100,
      ALU_SRL     = 4'b0101,
      ALU_SRA     = 4'b0110,
      ALU_OR      = 4'b0111,
      ALU_AND     = 4'b1000,
      ALU_SLT     = 4'b1011,
      ALU_ILLEGAL = 4'b1111
   } alu_op_e;

   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      alu_op_e     op;
      logic [4:0]  rd;
      logic        illegal;
   } dec_entry_t;

   // sub_en selects SUB over ADD, sra_en selects SRA over SRL.
   function automatic alu_op_e funct3_to_op(input logic [2:0] funct3,
                                            input logic       sub_en,
                                            input logic       sra_en);
      alu_op_e op;
      case (funct3)
         3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// Two-entry in-order buffer between decode and the ALU. in_ready_o is a
// register, so there is no combinational path from out_ready_i back upstream.
module alu_dec_skid #(
   parameter type T = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
   input  logic in_valid_i,
   output logic in_ready_o,
   input  T     in_data_i,
   output logic out_valid_o,
   input  logic out_ready_i,
   output T     out_data_o
);

   T           r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       r_in_ready;

   logic       w_push;
   logic       w_pop;
   logic [1:0] w_count_nxt;

   assign w_push = in_valid_i && r_in_ready;
   assign w_pop  = out_valid_o && out_ready_i;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 2'd1;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: storage is cleared on reset because its head drives the ALU operand ports, which must read zero.
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b0;
      end else if (flush_i) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data_i;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt != 2'd2);
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = (r_count != 2'd0);
   assign out_data_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode for OP/OP-IMM/LUI/AUIPC feeding a 2-entry ALU input buffer.
// Define ALU_DEC_ILLEGAL_EN to enqueue unsupported instructions flagged on illegal_o.
module alu_decode_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_val_i,
   input  logic [31:0] rs2_val_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [3:0]  alu_op_o,
   output logic [4:0]  rd_o
`ifdef ALU_DEC_ILLEGAL_EN
   ,
   output logic        illegal_o
`endif
);

   import alu_pkg::*;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_shift_imm;
   logic       w_supported;
   logic       w_enqueue;
   dec_entry_t w_entry;
   dec_entry_t w_out;

   assign w_opcode    = instr_i[6:0];
   assign w_funct3    = instr_i[14:12];
   assign w_funct7    = instr_i[31:25];
   assign w_shift_imm = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves a latch behind.
      w_entry     = '0;
      w_entry.op  = ALU_ADD;
      w_entry.rd  = instr_i[11:7];
      w_supported = 1'b1;
      case (w_opcode)
         OPC_OP: begin
            w_supported = (w_funct7 == FUNCT7_BASE) || (w_funct7 == FUNCT7_ALT);
            w_entry.a   = rs1_val_i;
            w_entry.b   = rs2_val_i;
            w_entry.op  = funct3_to_op(w_funct3, w_funct7[5], w_funct7[5]);
         end
         OPC_OP_IMM: begin
            w_entry.a  = rs1_val_i;
            w_entry.b  = w_shift_imm ? {27'd0, instr_i[24:20]}
                                     : {{20{instr_i[31]}}, instr_i[31:20]};
            w_entry.op = funct3_to_op(w_funct3, 1'b0, instr_i[30]);
         end
         OPC_LUI: begin
            w_entry.b = {instr_i[31:12], 12'h000};
         end
         OPC_AUIPC: begin
            w_entry.a = pc_i;
            w_entry.b = {instr_i[31:12], 12'h000};
         end
         default: begin
            w_supported = 1'b0;
         end
      endcase
      if (!w_supported) begin
         w_entry.a       = '0;
         w_entry.b       = '0;
         w_entry.op      = ALU_ILLEGAL;
         w_entry.illegal = 1'b1;
      end
   end

   // Unsupported instructions still complete the input handshake; only the enqueue differs.
`ifdef ALU_DEC_ILLEGAL_EN
   assign w_enqueue = in_valid_i;
`else
   assign w_enqueue = in_valid_i && w_supported;
`endif

   alu_dec_skid #(
      .T (dec_entry_t)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (w_enqueue),
      .in_ready_o  (in_ready_o),
      .in_data_i   (w_entry),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (w_out)
   );

   assign a_o      = w_out.a;
   assign b_o      = w_out.b;
   assign alu_op_o = w_out.op;
   assign rd_o     = w_out.rd;

`ifdef ALU_DEC_ILLEGAL_EN
   assign illegal_o = w_out.illegal;
`else
   logic w_unused_illegal;
   assign w_unused_illegal = w_out.illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed vector table, handshake
// corner sequences and random traffic against a queue-based reference model.
module tb_alu_decode_stage;

   logic        clk_i;
   logic        rst_i;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic [31:0] rs1_val_i;
   logic [31:0] rs2_val_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] a_o;
   logic [31:0] b_o;
   logic [3:0]  alu_op_o;
   logic [4:0]  rd_o;
`ifdef ALU_DEC_ILLEGAL_EN
   logic        illegal_o;
`endif

   alu_decode_stage dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .instr_i     (instr_i),
      .pc_i        (pc_i),
      .rs1_val_i   (rs1_val_i),
      .rs2_val_i   (rs2_val_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .a_o         (a_o),
      .b_o         (b_o),
      .alu_op_o    (alu_op_o),
      .rd_o        (rd_o)
`ifdef ALU_DEC_ILLEGAL_EN
      ,
      .illegal_o   (illegal_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        enq;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr, pc, rs1, rs2;
      logic        enq;
      logic [31:0] a, b;
      logic [3:0]  op;
      logic [4:0]  rd;
   } vec_t;

   int   total;
   int   bad;
   exp_t q[$];
   logic m_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] instr, pc, rs1, rs2);
      logic [3:0] f3_op [8];
      logic [2:0] f3;
      logic [6:0] f7;
      exp_t       r;
      f3_op = '{4'h0, 4'h2, 4'hB, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
      f3    = instr[14:12];
      f7    = instr[31:25];
      r     = '0;
      r.enq = 1'b1;
      r.rd  = instr[11:7];
      case (instr[6:0])
         7'b0110011: begin
            if (f7 == 7'h00 || f7 == 7'h20) begin
               r.a  = rs1;
               r.b  = rs2;
               r.op = f3_op[f3];
               if (f7 == 7'h20 && f3 == 3'd0) r.op = 4'h1;
               if (f7 == 7'h20 && f3 == 3'd5) r.op = 4'h6;
            end else begin
               r.enq = 1'b0;
            end
         end
         7'b0010011: begin
            r.a  = rs1;
            r.b  = (f3 == 3'd1 || f3 == 3'd5) ? 32'(instr[24:20]) : 32'($signed(instr[31:20]));
            r.op = f3_op[f3];
            if (f3 == 3'd5 && instr[30]) r.op = 4'h6;
         end
         7'b0110111: r.b = {instr[31:12], 12'h000};
         7'b0010111: begin
            r.a = pc;
            r.b = {instr[31:12], 12'h000};
         end
         default: r.enq = 1'b0;
      endcase
`ifdef ALU_DEC_ILLEGAL_EN
      if (!r.enq) begin
         r.enq = 1'b1;
         r.ill = 1'b1;
         r.a   = '0;
         r.b   = '0;
         r.op  = 4'hF;
      end
`endif
      return r;
   endfunction

   // Advance the model by one clock using the current inputs, then compare after the edge.
   task automatic cycle();
      exp_t e;
      logic acc;
      logic pop;
      if (rst_i) begin
         q.delete();
         m_ready = 1'b0;
      end else if (flush_i) begin
         q.delete();
         m_ready = 1'b1;
      end else begin
         acc = in_valid_i && m_ready;
         pop = (q.size() != 0) && out_ready_i;
         if (pop) void'(q.pop_front());
         if (acc) begin
            e = ref_decode(instr_i, pc_i, rs1_val_i, rs2_val_i);
            if (e.enq) q.push_back(e);
         end
         m_ready = (q.size() < 2);
      end
      @(posedge clk_i);
      #1;
      check("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready_o), 32'(m_ready));
      if (q.size() != 0) begin
         check("a", a_o, q[0].a);
         check("b", b_o, q[0].b);
         check("alu_op", 32'(alu_op_o), 32'(q[0].op));
         check("rd", 32'(rd_o), 32'(q[0].rd));
`ifdef ALU_DEC_ILLEGAL_EN
         check("illegal", 32'(illegal_o), 32'(q[0].ill));
`endif
      end
   endtask

   function automatic logic [31:0] mk_add(input logic [4:0] rd);
      return {7'b0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 6))
         0, 1: begin
            w[6:0] = 7'b0110011;
            case ($urandom_range(0, 2))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               default: ;
            endcase
         end
         2, 3: w[6:0] = 7'b0010011;
         4:    w[6:0] = 7'b0110111;
         5:    w[6:0] = 7'b0010111;
         default: ;
      endcase
      return w;
   endfunction

   vec_t vecs [17];
   logic want_v;

   initial begin
      total       = 0;
      bad         = 0;
      m_ready     = 1'b0;
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      instr_i     = '0;
      pc_i        = '0;
      rs1_val_i   = '0;
      rs2_val_i   = '0;

      vecs[0]  = '{32'h002081B3, 32'h0,    32'd5,        32'd7,  1'b1, 32'd5,        32'd7,        4'h0, 5'd3};
      vecs[1]  = '{32'h40415093, 32'h0,    32'h80000000, 32'd0,  1'b1, 32'h80000000, 32'd4,        4'h6, 5'd1};
      vecs[2]  = '{32'hFFF00093, 32'h0,    32'd0,        32'd0,  1'b1, 32'd0,        32'hFFFFFFFF, 4'h0, 5'd1};
      vecs[3]  = '{32'h407302B3, 32'h0,    32'd100,      32'd30, 1'b1, 32'd100,      32'd30,       4'h1, 5'd5};
      vecs[4]  = '{32'h12345537, 32'h40,   32'hDEADBEEF, 32'd1,  1'b1, 32'd0,        32'h12345000, 4'h0, 5'd10};
      vecs[5]  = '{32'hFFFFF117, 32'h1000, 32'hDEADBEEF, 32'd0,  1'b1, 32'h1000,     32'hFFFFF000, 4'h0, 5'd2};
      vecs[6]  = '{32'h0020A233, 32'h0,    32'd1,        32'd2,  1'b1, 32'd1,        32'd2,        4'hB, 5'd4};
      vecs[7]  = '{32'h8004B413, 32'h0,    32'h55,       32'd0,  1'b1, 32'h55,       32'hFFFFF800, 4'h3, 5'd8};
      vecs[8]  = '{32'h01F0D093, 32'h0,    32'hF0,       32'd0,  1'b1, 32'hF0,       32'd31,       4'h5, 5'd1};
      vecs[9]  = '{32'hFE519113, 32'h0,    32'd3,        32'd0,  1'b1, 32'd3,        32'd5,        4'h2, 5'd2};
      vecs[10] = '{32'h0020C3B3, 32'h0,    32'hA,        32'hC,  1'b1, 32'hA,        32'hC,        4'h4, 5'd7};
      vecs[11] = '{32'h0020E3B3, 32'h0,    32'hA,        32'hC,  1'b1, 32'hA,        32'hC,        4'h7, 5'd7};
      vecs[12] = '{32'h0020F3B3, 32'h0,    32'hA,        32'hC,  1'b1, 32'hA,        32'hC,        4'h8, 5'd7};
      vecs[13] = '{32'h4020D3B3, 32'h0,    32'hA,        32'hC,  1'b1, 32'hA,        32'hC,        4'h6, 5'd7};
      vecs[14] = '{32'h40000093, 32'h0,    32'd9,        32'd0,  1'b1, 32'd9,        32'h400,      4'h0, 5'd1};
      vecs[15] = '{32'h0000A083, 32'h0,    32'd1,        32'd2,  1'b0, 32'd0,        32'd0,        4'hF, 5'd1};
      vecs[16] = '{32'h022081B3, 32'h0,    32'd1,        32'd2,  1'b0, 32'd0,        32'd0,        4'hF, 5'd3};

      // Reset state.
      cycle();
      cycle();
      check("reset a", a_o, 32'd0);
      check("reset b", b_o, 32'd0);
      check("reset op", 32'(alu_op_o), 32'd0);
      check("reset rd", 32'(rd_o), 32'd0);
      rst_i = 1'b0;
      cycle();
      check("ready after reset", 32'(in_ready_o), 32'd1);

      // Directed decode vectors, one instruction at a time.
      out_ready_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid_i = 1'b1;
         instr_i    = vecs[i].instr;
         pc_i       = vecs[i].pc;
         rs1_val_i  = vecs[i].rs1;
         rs2_val_i  = vecs[i].rs2;
         cycle();
         in_valid_i = 1'b0;
         want_v     = vecs[i].enq;
`ifdef ALU_DEC_ILLEGAL_EN
         want_v     = 1'b1;
`endif
         check($sformatf("vec%0d valid", i), 32'(out_valid_o), 32'(want_v));
         if (out_valid_o && want_v) begin
            check($sformatf("vec%0d a", i), a_o, vecs[i].a);
            check($sformatf("vec%0d b", i), b_o, vecs[i].b);
            check($sformatf("vec%0d op", i), 32'(alu_op_o), 32'(vecs[i].op));
            check($sformatf("vec%0d rd", i), 32'(rd_o), 32'(vecs[i].rd));
`ifdef ALU_DEC_ILLEGAL_EN
            check($sformatf("vec%0d illegal", i), 32'(illegal_o), 32'(!vecs[i].enq));
`endif
         end
         cycle();
      end

      // Backpressure: third instruction must be refused while full.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      instr_i     = mk_add(5'd11);
      cycle();
      check("bp ready after 1", 32'(in_ready_o), 32'd1);
      instr_i = mk_add(5'd12);
      cycle();
      check("bp ready after 2", 32'(in_ready_o), 32'd0);
      instr_i = mk_add(5'd13);
      cycle();
      check("bp held ready", 32'(in_ready_o), 32'd0);
      check("bp head rd", 32'(rd_o), 32'd11);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      cycle();
      check("bp ready back", 32'(in_ready_o), 32'd1);
      check("bp second rd", 32'(rd_o), 32'd12);
      cycle();
      check("bp drained", 32'(out_valid_o), 32'd0);

      // Flush with two held entries and a simultaneous accept.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      instr_i     = mk_add(5'd21);
      cycle();
      instr_i = mk_add(5'd22);
      cycle();
      flush_i = 1'b1;
      instr_i = mk_add(5'd23);
      cycle();
      check("flush valid", 32'(out_valid_o), 32'd0);
      check("flush ready", 32'(in_ready_o), 32'd1);
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      cycle();
      check("flushed instr absent", 32'(out_valid_o), 32'd0);

      // Reset with two held entries and the ALU stalled.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      instr_i     = mk_add(5'd31);
      cycle();
      instr_i = mk_add(5'd32);
      cycle();
      in_valid_i = 1'b0;
      rst_i      = 1'b1;
      cycle();
      check("mid reset valid", 32'(out_valid_o), 32'd0);
      check("mid reset ready", 32'(in_ready_o), 32'd0);
      check("mid reset a", a_o, 32'd0);
      check("mid reset rd", 32'(rd_o), 32'd0);
      rst_i = 1'b0;
      cycle();
      check("post reset ready", 32'(in_ready_o), 32'd1);
      check("post reset valid", 32'(out_valid_o), 32'd0);

      // Random traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         in_valid_i  = ($urandom_range(0, 9) < 7);
         out_ready_i = ($urandom_range(0, 9) < 6);
         flush_i     = ($urandom_range(0, 39) == 0);
         rst_i       = ($urandom_range(0, 99) == 0);
         instr_i     = rand_instr();
         pc_i        = $urandom();
         rs1_val_i   = $urandom();
         rs2_val_i   = $urandom();
         cycle();
      end
      rst_i      = 1'b0;
      flush_i    = 1'b0;
      in_valid_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
